// File: rtl/cm0ik_rom_table_pkg.sv
// Shared constants for the multi-entry CoreSight ROM table: ID register offsets,
// CID byte values, entry format bits and the AHB data-phase FSM encoding.
package cm0ik_rom_table_pkg;

  localparam logic [11:0] OFS_SYSACCESS = 12'hFCC;
  localparam logic [11:0] OFS_PID4      = 12'hFD0;
  localparam logic [11:0] OFS_PID0      = 12'hFE0;
  localparam logic [11:0] OFS_PID1      = 12'hFE4;
  localparam logic [11:0] OFS_PID2      = 12'hFE8;
  localparam logic [11:0] OFS_PID3      = 12'hFEC;
  localparam logic [11:0] OFS_CID0      = 12'hFF0;
  localparam logic [11:0] OFS_CID1      = 12'hFF4;
  localparam logic [11:0] OFS_CID2      = 12'hFF8;
  localparam logic [11:0] OFS_CID3      = 12'hFFC;

  localparam logic [7:0] CID0_VAL = 8'h0D;
  localparam logic [7:0] CID1_VAL = 8'h10;
  localparam logic [7:0] CID2_VAL = 8'h05;
  localparam logic [7:0] CID3_VAL = 8'hB1;

  // Bit 1 marks a 32-bit format entry; bit 0 is filled with the present flag.
  localparam logic [1:0] ENTRY_FMT = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  function automatic logic [31:0] entry_word(input logic [19:0] base, input logic present);
    return {base, 10'b0, ENTRY_FMT | {1'b0, present}};
  endfunction

endpackage

// File: rtl/cm0ik_rom_table_decode.sv
// Combinational ROM table read decode: word address -> 32-bit register value.
// Zero latency, no flow control; unmapped words (including the end marker) read 0.
module cm0ik_rom_table_decode
  import cm0ik_rom_table_pkg::*;
#(
  parameter int NUM_ENTRIES = 4
) (
  input  logic [9:0]               word_addr,
  input  logic [6:0]               jepid,
  input  logic [3:0]               jepcontinuation,
  input  logic [11:0]              partnumber,
  input  logic [3:0]               revision,
  input  logic [3:0]               revand,
  input  logic                     sysaccess,
  input  logic [32*NUM_ENTRIES-1:0] entry_addr,
  input  logic [NUM_ENTRIES-1:0]   entry_present,
  output logic [31:0]              rdata
);

  logic [12*NUM_ENTRIES-1:0] entry_lo_unused;

  always_comb begin
    entry_lo_unused = '0;
    for (int k = 0; k < NUM_ENTRIES; k++) begin
      entry_lo_unused[12*k +: 12] = entry_addr[32*k +: 12];
    end
  end

  always_comb begin
    rdata = '0;
    // Entry words sit below 0x40 and never overlap the ID block at 0xFCC+.
    for (int k = 0; k < NUM_ENTRIES; k++) begin
      if (word_addr == 10'(k)) begin
        rdata = entry_word(entry_addr[32*k+12 +: 20], entry_present[k]);
      end
    end
    case ({word_addr, 2'b00})
      OFS_SYSACCESS: rdata = {31'b0, sysaccess};
      OFS_PID4:      rdata = {24'b0, 4'h0, jepcontinuation};
      OFS_PID0:      rdata = {24'b0, partnumber[7:0]};
      OFS_PID1:      rdata = {24'b0, jepid[3:0], partnumber[11:8]};
      OFS_PID2:      rdata = {24'b0, revision, 1'b1, jepid[6:4]};
      OFS_PID3:      rdata = {24'b0, revand, 4'h0};
      OFS_CID0:      rdata = {24'b0, CID0_VAL};
      OFS_CID1:      rdata = {24'b0, CID1_VAL};
      OFS_CID2:      rdata = {24'b0, CID2_VAL};
      OFS_CID3:      rdata = {24'b0, CID3_VAL};
      default:       ;
    endcase
  end

endmodule

// File: rtl/cm0ik_rom_table_ahb.sv
// AHB-Lite ROM table slave: decode in address phase, data registered, WAIT_STATES extra
// read cycles, two-cycle ERROR on writes when enabled; stalls the bus via hreadyout only.
module cm0ik_rom_table_ahb
  import cm0ik_rom_table_pkg::*;
#(
  parameter int NUM_ENTRIES  = 4,
  parameter int WAIT_STATES  = 0,
  parameter int ERR_ON_WRITE = 1
) (
  input  logic                      hclk,
  input  logic                      hreset,
  input  logic                      hsel,
  input  logic [11:0]               haddr,
  input  logic [1:0]                htrans,
  input  logic                      hwrite,
  input  logic [2:0]                hsize,
  input  logic                      hready,
  output logic                      hreadyout,
  output logic                      hresp,
  output logic [31:0]               hrdata,
  input  logic [6:0]                jepid,
  input  logic [3:0]                jepcontinuation,
  input  logic [11:0]               partnumber,
  input  logic [3:0]                revision,
  input  logic [3:0]                revand,
  input  logic                      sysaccess,
  input  logic [32*NUM_ENTRIES-1:0] entry_addr,
  input  logic [NUM_ENTRIES-1:0]    entry_present
);

  localparam logic [1:0] WCNT_INIT = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

  state_t      state;
  logic [1:0]  wcnt;
  logic [31:0] rdata_q;
  logic [31:0] dec_data;
  logic        accept;
  logic        unused_ok;

  assign unused_ok = ^{hsize, htrans[0], haddr[1:0]};
  assign accept    = hsel & htrans[1] & hready;
  assign hrdata    = rdata_q;

  cm0ik_rom_table_decode #(
    .NUM_ENTRIES(NUM_ENTRIES)
  ) u_decode (
    .word_addr      (haddr[11:2]),
    .jepid          (jepid),
    .jepcontinuation(jepcontinuation),
    .partnumber     (partnumber),
    .revision       (revision),
    .revand         (revand),
    .sysaccess      (sysaccess),
    .entry_addr     (entry_addr),
    .entry_present  (entry_present),
    .rdata          (dec_data)
  );

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state     <= ST_IDLE;
      wcnt      <= 2'd0;
      hreadyout <= 1'b1;
      hresp     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      case (state)
        ST_WAIT: begin
          if (wcnt == 2'd0) begin
            state     <= ST_IDLE;
            hreadyout <= 1'b1;
          end else begin
            wcnt <= wcnt - 2'd1;
          end
        end
        ST_ERR1: begin
          state     <= ST_ERR2;
          hreadyout <= 1'b1;
          hresp     <= 1'b1;
        end
        default: begin
          // IDLE and ERR2 both end a data phase, so both may take a new address.
          state     <= ST_IDLE;
          hreadyout <= 1'b1;
          hresp     <= 1'b0;
          rdata_q   <= '0;
          if (accept && !hwrite) begin
            rdata_q <= dec_data;
            if (WAIT_STATES > 0) begin
              state     <= ST_WAIT;
              wcnt      <= WCNT_INIT;
              hreadyout <= 1'b0;
            end
          end else if (accept && (ERR_ON_WRITE != 0)) begin
            state     <= ST_ERR1;
            hreadyout <= 1'b0;
            hresp     <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
